// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares the memory data port between fetch and ld/st.    |
// | Optional ARB_ROUND_ROBIN_EN: alternating priority, no starvation counter. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  inout  wire  [31:0] mem_bus,
  output logic        mem_cs,
  output logic        mem_rw,
  output logic [1:0]  mem_mode,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [32:0] c_mem_lo = {1'b0, MEM_BASE};
  localparam logic [32:0] c_mem_hi = c_mem_lo + 33'(MEM_WORDS * 4);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sel_d;
  logic        r_rw;
  logic [1:0]  r_mode;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_fault;
  logic        r_bus_oe;

  logic        w_any_req;
  logic        w_pick_d;
  logic        w_rw;
  logic [1:0]  w_mode;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_fault;
  logic [31:0] w_rdata_cap;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
`else
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;
`endif

  assign w_any_req = i_req | d_req;
  assign busy      = (r_state != S_IDLE);
  assign mem_bus   = r_bus_oe ? r_wdata : 'z;

  always_comb begin
    w_pick_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && i_req) w_pick_d = !r_last_d;
`else
    if (d_req && i_req && (r_starve_cnt == c_starve_limit)) w_pick_d = 1'b0;
`endif
  end

  // Fetches are always aligned word reads.
  assign w_addr  = w_pick_d ? d_addr : i_addr;
  assign w_mode  = w_pick_d ? d_mode : 2'd2;
  assign w_rw    = w_pick_d & d_rw;
  assign w_wdata = w_pick_d ? d_wdata : 32'd0;

  always_comb begin
    w_fault = ({1'b0, w_addr} < c_mem_lo) || ({1'b0, w_addr} >= c_mem_hi);
    case (w_mode)
      2'd1:    if (w_addr[0]) w_fault = 1'b1;
      2'd2:    if (w_addr[1:0] != 2'd0) w_fault = 1'b1;
      2'd3:    w_fault = 1'b1;
      default: ;
    endcase
  end

  assign w_rdata_cap = (r_fault || r_rw) ? 32'd0 : mem_bus;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // State names the cycle in which the decision is made; the visible
  // memory strobe and rvalid appear one cycle later from these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      i_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      i_err       <= 1'b0;
      d_err       <= 1'b0;
      i_rdata     <= 32'd0;
      d_rdata     <= 32'd0;
      mem_cs      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_mode    <= 2'd0;
      mem_address <= 32'd0;
      r_bus_oe    <= 1'b0;
      r_sel_d     <= 1'b0;
      r_rw        <= 1'b0;
      r_mode      <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_fault     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d    <= 1'b1;
`else
      r_starve_cnt <= 4'd0;
`endif
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            d_gnt   <= w_pick_d;
            i_gnt   <= !w_pick_d;
            r_sel_d <= w_pick_d;
            r_rw    <= w_rw;
            r_mode  <= w_mode;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_fault <= w_fault;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d <= w_pick_d;
`else
            if (!w_pick_d)  r_starve_cnt <= 4'd0;
            else if (i_req) r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
          end
        end
        S_ISSUE: begin
          mem_cs   <= !r_fault;
          r_bus_oe <= !r_fault && r_rw;
          if (!r_fault) begin
            mem_address <= r_addr;
            mem_rw      <= r_rw;
            mem_mode    <= r_mode;
          end
        end
        S_RESP: begin
          mem_cs   <= 1'b0;
          r_bus_oe <= 1'b0;
          if (r_sel_d) begin
            d_rvalid <= 1'b1;
            d_err    <= r_fault;
            d_rdata  <= w_rdata_cap;
          end else begin
            i_rvalid <= 1'b1;
            i_err    <= r_fault;
            i_rdata  <= w_rdata_cap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Directed bench for mem_port_arbiter with a small word memory behind the data port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_rw;
  logic [1:0]  d_mode;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  wire  [31:0] mem_bus;
  logic        mem_cs, mem_rw;
  logic [1:0]  mem_mode;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem [0:15];

  mem_port_arbiter #(
    .MEM_BASE(32'h8000_0000),
    .MEM_WORDS(4096),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_rw(d_rw), .d_mode(d_mode), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err), .mem_address(mem_address), .mem_bus(mem_bus),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_mode(mem_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: word i holds 0x1000+i after reset; reads drive the bus while selected.
  assign mem_bus = (mem_cs && !mem_rw) ? mem[mem_address[5:2]] : 'z;
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h1000 + 32'(k);
    end else if (mem_cs && mem_rw) begin
      mem[mem_address[5:2]] <= mem_bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; walks gnt (N), issue (N+1), response (N+2).
  task automatic d_access(input string tag, input logic rw, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
    d_req = 1'b1; d_rw = rw; d_mode = mode; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    check({tag, "_gnt"}, d_gnt, 1);
    check({tag, "_ignt"}, i_gnt, 0);
    d_req = 1'b0;
    @(negedge clk);
    check({tag, "_cs"}, mem_cs, !exp_err);
    if (!exp_err) begin
      check({tag, "_addr"}, mem_address, addr);
      check({tag, "_rw"}, mem_rw, rw);
      check({tag, "_mode"}, mem_mode, mode);
      if (rw) check({tag, "_bus"}, mem_bus, wdata);
    end
    @(negedge clk);
    check({tag, "_cs2"}, mem_cs, 0);
    check({tag, "_rvalid"}, d_rvalid, 1);
    check({tag, "_err"}, d_err, exp_err);
    check({tag, "_rdata"}, d_rdata, exp_rdata);
  endtask

  initial begin
    logic [9:0] order;
    logic [9:0] exp_order;
    int n_gnt;
    int n_both;
    int n_stray;

    rst = 1'b1; i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_rw = 1'b0; d_mode = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {i_gnt, d_gnt}, 0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check("rst_err", {i_err, d_err}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_rw_mode", {mem_rw, mem_mode}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    d_access("st_word", 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0);
    d_access("ld_word", 1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, 32'hDEAD_BEEF);
    d_access("ld_below", 1'b0, 2'd2, 32'h7FFF_FFFC, 32'd0, 1'b1, 32'd0);
    d_access("st_misal", 1'b1, 2'd2, 32'h8000_0002, 32'h1234_5678, 1'b1, 32'd0);
    d_access("ld_last", 1'b0, 2'd2, 32'h8000_3FFC, 32'd0, 1'b0, 32'h0000_100F);
    d_access("ld_past", 1'b0, 2'd2, 32'h8000_4000, 32'd0, 1'b1, 32'd0);
    d_access("ld_half_odd", 1'b0, 2'd1, 32'h8000_0001, 32'd0, 1'b1, 32'd0);
    d_access("ld_mode3", 1'b0, 2'd3, 32'h8000_0000, 32'd0, 1'b1, 32'd0);
    d_access("ld_byte", 1'b0, 2'd0, 32'h8000_0003, 32'd0, 1'b0, 32'h0000_1000);

    // Both requesters held continuously; record ten grants (1 = data).
    i_req = 1'b1; i_addr = 32'h8000_0000;
    d_req = 1'b1; d_rw = 1'b0; d_mode = 2'd2; d_addr = 32'h8000_0004;
    order = '0; n_gnt = 0; n_both = 0;
    for (int cyc = 0; cyc < 60 && n_gnt < 10; cyc++) begin
      @(negedge clk);
      if (d_gnt && i_gnt) n_both++;
      if (d_gnt || i_gnt) begin
        order = {order[8:0], d_gnt};
        n_gnt++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 10'b0101010101;
`else
    exp_order = 10'b1111011110;
`endif
    check("tie_count", n_gnt, 10);
    check("tie_order", order, exp_order);
    check("tie_both", n_both, 0);
    repeat (3) @(negedge clk);

    // Reset while the memory strobe is up: the access is dropped.
    d_req = 1'b1; d_rw = 1'b0; d_mode = 2'd2; d_addr = 32'h8000_0010;
    @(negedge clk);
    check("ra_gnt", d_gnt, 1);
    d_req = 1'b0;
    @(negedge clk);
    check("ra_cs_pre", mem_cs, 1);
    rst = 1'b1;
    @(negedge clk);
    check("ra_cs", mem_cs, 0);
    check("ra_rvalid", d_rvalid, 0);
    check("ra_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ra_rvalid2", d_rvalid, 0);

    // Fetch after reset; a data request raised only while busy must be ignored.
    i_req = 1'b1; i_addr = 32'h8000_0000;
    @(negedge clk);
    check("f_gnt", i_gnt, 1);
    i_req = 1'b0;
    d_req = 1'b1; d_rw = 1'b0; d_mode = 2'd2; d_addr = 32'h8000_0008;
    @(negedge clk);
    check("f_cs", mem_cs, 1);
    check("f_mode", {mem_rw, mem_mode}, 3'b010);
    check("f_addr", mem_address, 32'h8000_0000);
    d_req = 1'b0;
    n_stray = 0;
    @(negedge clk);
    if (d_gnt) n_stray++;
    check("f_rvalid", i_rvalid, 1);
    check("f_err", i_err, 0);
    check("f_rdata", i_rdata, 32'h0000_1000);
    check("f_drvalid", d_rvalid, 0);
    repeat (4) begin
      @(negedge clk);
      if (d_gnt) n_stray++;
    end
    check("drop_no_gnt", n_stray, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
